imem_loader: RTL and testbench

Writes a program image into instruction memory from an 8-bit byte stream and holds the processor until the image is complete and verified. It owns the write port of instruction memory; the program counter side is the read port. It sits beside `top`. `cpu_hold` gates the processor reset, so fetch from address 0 begins only after a good load.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader.sv | 123 ++++++++++++
 tb/tb_imem_loader.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction memory loader
//   state_t       - loader FSM states
//   INSTR_W       - instruction width in bits (two stream bytes)
//   HI_BYTE_FIRST - stream byte order within an instruction
package imem_loader_pkg;

    localparam int INSTR_W       = 16;
    localparam bit HI_BYTE_FIRST = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_HI,
        S_LO,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/imem_loader.sv
// imem_loader: loads a checksummed byte-stream program image into instruction memory
//   i_clk          - clock, rising edge
//   i_rst_n        - asynchronous active-low reset
//   i_start        - one-cycle load request (honoured in IDLE/DONE/ERR)
//   i_in_valid     - stream byte valid
//   i_in_data      - stream byte
//   o_in_ready     - loader accepts a byte this cycle
//   o_imem_we      - instruction memory write strobe
//   o_imem_addr    - instruction memory write address
//   o_imem_wdata   - instruction memory write data
//   o_cpu_hold     - holds the processor in reset until a good load completes
//   o_done         - last load succeeded
//   o_err          - last load failed
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_in_valid,
    input  logic [7:0]         i_in_data,
    output logic               o_in_ready,
    output logic               o_imem_we,
    output logic [ADDR_W-1:0]  o_imem_addr,
    output logic [INSTR_W-1:0] o_imem_wdata,
    output logic               o_cpu_hold,
    output logic               o_done,
    output logic               o_err
);

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_sum;
    logic [7:0]         r_hi;
    logic [ADDR_W-1:0]  r_idx;
    logic [ADDR_W-1:0]  r_last;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_we;
    logic [INSTR_W-1:0] r_wdata;
    logic               w_xfer;
    logic               w_start;
    logic               w_c_ovf;
    logic               w_last;

    assign w_xfer  = i_in_valid && o_in_ready;
    assign w_start = i_start && (r_state inside {S_IDLE, S_DONE, S_ERR});
    // A count byte naming more instructions than the memory holds is rejected.
    assign w_c_ovf = 32'(i_in_data) >= (32'd1 << ADDR_W);
    // r_idx counts instructions already written, so it equals C on the Nth one.
    assign w_last  = r_idx == r_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: w_next = i_start ? S_COUNT : r_state;
            S_COUNT: if (w_xfer) w_next = w_c_ovf ? S_ERR : S_HI;
            S_HI:    if (w_xfer) w_next = S_LO;
            S_LO:    if (w_xfer) w_next = w_last ? S_CSUM : S_HI;
            S_CSUM:  if (w_xfer) w_next = (i_in_data == r_sum) ? S_DONE : S_ERR;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_in_ready = r_state inside {S_COUNT, S_HI, S_LO, S_CSUM};
        o_cpu_hold = r_state != S_DONE;
        o_done     = r_state == S_DONE;
        o_err      = r_state == S_ERR;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sum   <= '0;
            r_hi    <= '0;
            r_idx   <= '0;
            r_last  <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_we <= w_xfer && (r_state == S_LO);
            // The write cycle of the final instruction falls in CSUM; the
            // address is left on it so it never wraps past the top word.
            if (w_start) begin
                r_idx  <= '0;
                r_addr <= '0;
            end else if (r_we && r_state != S_CSUM) begin
                r_addr <= r_addr + 1'b1;
            end
            if (w_xfer) begin
                case (r_state)
                    S_COUNT: begin
                        r_sum  <= i_in_data;
                        r_last <= ADDR_W'(i_in_data);
                    end
                    S_HI: begin
                        r_hi  <= i_in_data;
                        r_sum <= r_sum + i_in_data;
                    end
                    S_LO: begin
                        r_sum   <= r_sum + i_in_data;
                        r_idx   <= r_idx + 1'b1;
                        r_wdata <= HI_BYTE_FIRST ? INSTR_W'({r_hi, i_in_data}) : INSTR_W'({i_in_data, r_hi});
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_imem_we    = r_we;
    assign o_imem_addr  = r_addr;
    assign o_imem_wdata = r_wdata;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader against a memory/scoreboard model
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        o_in_ready;
    logic        o_imem_we;
    logic [7:0]  o_imem_addr;
    logic [15:0] o_imem_wdata;
    logic        o_cpu_hold;
    logic        o_done;
    logic        o_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [23:0] exp_q[$];
    logic [15:0] model_mem[256];
    logic [15:0] tb_mem[256];
    logic [7:0]  last_addr;

    imem_loader #(.ADDR_W(8), .INSTR_W(16)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (i_start),
        .i_in_valid   (in_valid),
        .i_in_data    (in_data),
        .o_in_ready   (o_in_ready),
        .o_imem_we    (o_imem_we),
        .o_imem_addr  (o_imem_addr),
        .o_imem_wdata (o_imem_wdata),
        .o_cpu_hold   (o_cpu_hold),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instruction memory stand-in: every write must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && o_imem_we) begin
            if (exp_q.size() == 0) begin
                chk("spurious_we", 32'd1, 32'd0);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                chk("we_addr", 32'(o_imem_addr), 32'(e[23:16]));
                chk("we_data", 32'(o_imem_wdata), 32'(e[15:0]));
            end
            tb_mem[o_imem_addr] = o_imem_wdata;
            last_addr = o_imem_addr;
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(o_in_ready), 0);
        chk({tag, "_we"},    32'(o_imem_we), 0);
        chk({tag, "_addr"},  32'(o_imem_addr), 0);
        chk({tag, "_wdata"}, 32'(o_imem_wdata), 0);
        chk({tag, "_hold"},  32'(o_cpu_hold), 1);
        chk({tag, "_done"},  32'(o_done), 0);
        chk({tag, "_err"},   32'(o_err), 0);
    endtask

    task automatic check_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < 256; i++) if (tb_mem[i] !== model_mem[i]) bad++;
        chk({tag, "_mem"}, 32'(bad), 0);
    endtask

    // Drives a byte list with random valid gaps; optionally pulses start mid-stream.
    task automatic send(input logic [7:0] s[$], input int stall, input bit poke);
        int i = 0;
        int cyc = 0;
        bit xfer;
        while (i < s.size() && cyc < 5000) begin
            @(negedge clk);
            i_start = poke && ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) < stall) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = s[i];
            end
            xfer = in_valid && o_in_ready;
            @(posedge clk);
            if (xfer) i++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        i_start  = 1'b0;
        chk("stream_timeout", 32'(cyc < 5000), 1);
    endtask

    task automatic pulse_start(input string tag);
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk({tag, "_ready_after_start"}, 32'(o_in_ready), 1);
        chk({tag, "_hold_after_start"},  32'(o_cpu_hold), 1);
    endtask

    // Builds the stream from the image, predicts the writes and the result, then runs it.
    task automatic do_load(input string tag, input logic [15:0] w[$], input bit bad, input int stall, input bit poke);
        logic [7:0] s[$];
        logic [7:0] sum = 8'h00;
        s.push_back(8'(w.size() - 1));
        foreach (w[i]) begin
            s.push_back(w[i][15:8]);
            s.push_back(w[i][7:0]);
        end
        foreach (s[i]) sum += s[i];
        s.push_back(bad ? sum + 8'h01 : sum);
        foreach (w[i]) begin
            exp_q.push_back({8'(i), w[i]});
            model_mem[i] = w[i];
        end
        pulse_start(tag);
        send(s, stall, poke);
        chk({tag, "_done"}, 32'(o_done), bad ? 0 : 1);
        chk({tag, "_err"},  32'(o_err),  bad ? 1 : 0);
        chk({tag, "_hold"}, 32'(o_cpu_hold), bad ? 1 : 0);
        chk({tag, "_writes_left"}, 32'(exp_q.size()), 0);
        check_mem(tag);
    endtask

    initial begin
        logic [15:0] w[$];
        logic [7:0]  s[$];
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = 16'(i * 7 + 3);
            tb_mem[i]    = 16'(i * 7 + 3);
        end
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("idle");

        w = '{16'h1234, 16'h5678, 16'h9ABC};
        do_load("good3", w, 1'b0, 0, 1'b0);
        do_load("badcs", w, 1'b1, 0, 1'b0);

        w = {};
        for (int i = 0; i < 256; i++) w.push_back(16'(i * 16'h0101));
        do_load("max", w, 1'b0, 0, 1'b0);
        chk("max_last_addr", 32'(last_addr), 32'hFF);
        chk("max_addr_hold", 32'(o_imem_addr), 32'hFF);

        w = '{16'h1234, 16'h5678, 16'h9ABC};
        do_load("stall", w, 1'b0, 40, 1'b1);

        // Reset after the 2nd instruction's high byte: only word 0 is written.
        exp_q.push_back({8'h00, 16'h1234});
        model_mem[0] = 16'h1234;
        pulse_start("midrst");
        s = '{8'h02, 8'h12, 8'h34, 8'h56};
        send(s, 20, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_writes_left", 32'(exp_q.size()), 0);
        check_reset_vals("midrst_idle");
        check_mem("midrst");
        w = '{16'h0F0F, 16'hA5A5, 16'h0001};
        do_load("after_rst", w, 1'b0, 25, 1'b0);

        w = '{16'hABCD};
        do_load("reload", w, 1'b0, 0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            w = {};
            for (int i = 0, n = $urandom_range(1, 12); i < n; i++) w.push_back(16'($urandom));
            do_load($sformatf("rnd%0d", t), w, 1'($urandom_range(0, 1)), $urandom_range(0, 50), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
